// File: rtl/hyperbus_pkg.sv
// Shared encodings and helpers for the hbus arbitration blocks.
package hyperbus_pkg;
    localparam logic [2:0] ARB_IDLE  = 3'b001;
    localparam logic [2:0] ARB_OWN   = 3'b010;
    localparam logic [2:0] ARB_DRAIN = 3'b100;

    localparam int MAX_PORTS = 4;

    function automatic logic [MAX_PORTS-1:0] port_onehot(input int idx);
        port_onehot = MAX_PORTS'(1) << idx;
    endfunction
endpackage

// File: rtl/hyperbus_rr_pick.sv
// Combinational round-robin picker: first requester strictly after 'last', wrapping.
module hyperbus_rr_pick
    import hyperbus_pkg::*;
#(
    parameter int N  = 2,
    parameter int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  gnt_onehot,
    output logic [LW-1:0] idx
);
    int   c;
    logic found;

    always_comb begin
        gnt_onehot = '0;
        idx        = '0;
        found      = 1'b0;
        c          = 0;
        for (int i = 1; i <= N; i++) begin
            c = (int'(last) + i) % N;
            if (!found && req[c[LW-1:0]]) begin
                found      = 1'b1;
                idx        = c[LW-1:0];
                gnt_onehot = N'(port_onehot(c));
            end
        end
    end
endmodule

// File: rtl/hyperbus_arbiter.sv
// Round-robin arbiter sharing one Hyperbus controller between NUM_PORTS masters.
// Optional watchdog abort enabled with `define HBUS_ARB_TIMEOUT_EN.
module hyperbus_arbiter
    import hyperbus_pkg::*;
#(
    parameter int NUM_PORTS       = 2,
    parameter int HBUS_ADDR_WIDTH = 32,
    parameter int HBUS_DATA_WIDTH = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                                 hbus_clk,
    input  logic                                 hbus_rst,
    input  logic [NUM_PORTS-1:0]                 m_rrq,
    input  logic [NUM_PORTS-1:0]                 m_wrq,
    input  logic [NUM_PORTS*HBUS_ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_PORTS*HBUS_DATA_WIDTH-1:0] m_dat_i,
    output logic [HBUS_DATA_WIDTH-1:0]           m_dat_o,
    output logic [NUM_PORTS-1:0]                 m_ready,
    output logic [NUM_PORTS-1:0]                 m_valid,
    output logic [NUM_PORTS-1:0]                 m_gnt,
    output logic [NUM_PORTS-1:0]                 m_timeout,
    output logic [HBUS_ADDR_WIDTH-1:0]           hbus_adr_o,
    output logic [HBUS_DATA_WIDTH-1:0]           hbus_dat_o,
    input  logic [HBUS_DATA_WIDTH-1:0]           hbus_dat_i,
    output logic                                 hbus_rrq,
    output logic                                 hbus_wrq,
    input  logic                                 hbus_ready,
    input  logic                                 hbus_valid,
    input  logic                                 hbus_busy
);
    localparam int LW = $clog2(NUM_PORTS);

    if (NUM_PORTS < 2 || NUM_PORTS > MAX_PORTS || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("hyperbus_arbiter: illegal parameter combination");
    end

    logic [2:0]           state;
    logic [LW-1:0]        last_port;
    logic [NUM_PORTS-1:0] req_any;
    logic [NUM_PORTS-1:0] req_elig;
    logic [NUM_PORTS-1:0] pick_gnt;
    logic [LW-1:0]        pick_idx;
    logic                 owner_req;
    logic                 owner_rd;
    logic                 abort;

    assign req_any   = m_rrq | m_wrq;
    assign owner_req = |(req_any & m_gnt);
    assign owner_rd  = |(m_rrq & m_gnt);

`ifdef HBUS_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES);

    logic [WW-1:0]        wd_cnt;
    logic [NUM_PORTS-1:0] blk;

    assign abort    = (state == ARB_OWN) && (wd_cnt == WW'(TIMEOUT_CYCLES - 1));
    // An aborted master must drop its request once before it is eligible again.
    assign req_elig = req_any & ~blk;

    always_ff @(posedge hbus_clk or posedge hbus_rst) begin
        if (hbus_rst) begin
            wd_cnt    <= '0;
            blk       <= '0;
            m_timeout <= '0;
        end else begin
            m_timeout <= abort ? m_gnt : '0;
            blk       <= (blk & req_any) | (abort ? m_gnt : '0);
            if (state == ARB_IDLE) wd_cnt <= '0;
            else                   wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign abort     = 1'b0;
    assign req_elig  = req_any;
    assign m_timeout = '0;
`endif

    hyperbus_rr_pick #(.N(NUM_PORTS), .LW(LW)) u_pick (
        .req        (req_elig),
        .last       (last_port),
        .gnt_onehot (pick_gnt),
        .idx        (pick_idx)
    );

    always_ff @(posedge hbus_clk or posedge hbus_rst) begin
        if (hbus_rst) begin
            state     <= ARB_IDLE;
            m_gnt     <= '0;
            last_port <= LW'(NUM_PORTS - 1);
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|pick_gnt && !hbus_busy) begin
                        m_gnt     <= pick_gnt;
                        last_port <= pick_idx;
                        state     <= ARB_OWN;
                    end
                end
                ARB_OWN: begin
                    if (abort || !owner_req) state <= ARB_DRAIN;
                end
                ARB_DRAIN: begin
                    if (!hbus_busy) begin
                        m_gnt <= '0;
                        state <= ARB_IDLE;
                    end
                end
                default: begin
                    m_gnt <= '0;
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign hbus_rrq = (state == ARB_OWN) && owner_rd;
    assign hbus_wrq = (state == ARB_OWN) && |(m_wrq & m_gnt) && !owner_rd;
    assign m_ready  = {NUM_PORTS{hbus_ready}} & m_gnt;
    assign m_valid  = {NUM_PORTS{hbus_valid}} & m_gnt;
    assign m_dat_o  = hbus_dat_i;

    // One-hot grant makes an OR-mux sufficient; zero when nobody owns the bus.
    always_comb begin
        hbus_adr_o = '0;
        hbus_dat_o = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (m_gnt[k]) begin
                hbus_adr_o = hbus_adr_o | m_adr_i[k*HBUS_ADDR_WIDTH +: HBUS_ADDR_WIDTH];
                hbus_dat_o = hbus_dat_o | m_dat_i[k*HBUS_DATA_WIDTH +: HBUS_DATA_WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_hyperbus_arbiter.sv
// Directed self-checking bench for hyperbus_arbiter (2 ports).
module tb_hyperbus_arbiter;
   localparam int NP = 2;
   localparam int AW = 32;
   localparam int DW = 16;

   logic             hbus_clk = 1'b0;
   logic             hbus_rst;
   logic [NP-1:0]    m_rrq, m_wrq;
   logic [NP*AW-1:0] m_adr_i;
   logic [NP*DW-1:0] m_dat_i;
   logic [DW-1:0]    m_dat_o;
   logic [NP-1:0]    m_ready, m_valid, m_gnt, m_timeout;
   logic [AW-1:0]    hbus_adr_o;
   logic [DW-1:0]    hbus_dat_o, hbus_dat_i;
   logic             hbus_rrq, hbus_wrq, hbus_ready, hbus_valid, hbus_busy;

   int tests = 0;
   int fails = 0;

   hyperbus_arbiter #(
      .NUM_PORTS(NP), .HBUS_ADDR_WIDTH(AW), .HBUS_DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
   ) dut (
      .hbus_clk(hbus_clk), .hbus_rst(hbus_rst),
      .m_rrq(m_rrq), .m_wrq(m_wrq), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
      .m_dat_o(m_dat_o), .m_ready(m_ready), .m_valid(m_valid), .m_gnt(m_gnt),
      .m_timeout(m_timeout), .hbus_adr_o(hbus_adr_o), .hbus_dat_o(hbus_dat_o),
      .hbus_dat_i(hbus_dat_i), .hbus_rrq(hbus_rrq), .hbus_wrq(hbus_wrq),
      .hbus_ready(hbus_ready), .hbus_valid(hbus_valid), .hbus_busy(hbus_busy)
   );

   always #5 hbus_clk = ~hbus_clk;

   task automatic tick(input int n = 1);
      repeat (n) @(posedge hbus_clk);
      #1;
   endtask

   initial begin
      hbus_rst   = 1'b1;
      m_rrq      = '0;
      m_wrq      = '0;
      m_adr_i    = {32'h0000_0200, 32'h0000_0100};
      m_dat_i    = {16'h5555, 16'hAAAA};
      hbus_dat_i = '0;
      hbus_ready = 1'b1;
      hbus_valid = 1'b1;
      hbus_busy  = 1'b0;
      tick(2);
      tests++; if (m_gnt !== 2'b00) begin fails++; $error("FAIL rst_gnt: got %0h", m_gnt); end
      tests++; if (hbus_rrq !== 1'b0) begin fails++; $error("FAIL rst_rrq: got %0h", hbus_rrq); end
      tests++; if (hbus_wrq !== 1'b0) begin fails++; $error("FAIL rst_wrq: got %0h", hbus_wrq); end
      tests++; if (m_ready !== 2'b00) begin fails++; $error("FAIL rst_ready: got %0h", m_ready); end
      tests++; if (m_valid !== 2'b00) begin fails++; $error("FAIL rst_valid: got %0h", m_valid); end
      tests++; if (m_timeout !== 2'b00) begin fails++; $error("FAIL rst_timeout: got %0h", m_timeout); end
      tests++; if (hbus_adr_o !== 32'h0) begin fails++; $error("FAIL rst_adr: got %0h", hbus_adr_o); end
      hbus_ready = 1'b0;
      hbus_valid = 1'b0;
      hbus_rst   = 1'b0;
      tick();

      for (int i = 0; i < 4; i++) begin
         logic [1:0]  eg;
         logic [15:0] ed;
         eg = (i % 2 == 0) ? 2'b01 : 2'b10;
         ed = (i % 2 == 0) ? 16'hAAAA : 16'h5555;
         m_wrq = 2'b11;
         hbus_ready = 1'b1;
         tick();
         tests++; if (m_gnt !== eg) begin fails++; $error("FAIL rr_gnt: got %0h exp %0h", m_gnt, eg); end
         tests++; if (hbus_wrq !== 1'b1) begin fails++; $error("FAIL rr_wrq: got %0h", hbus_wrq); end
         tests++; if (hbus_dat_o !== ed) begin fails++; $error("FAIL rr_dat: got %0h exp %0h", hbus_dat_o, ed); end
         tests++; if (m_ready !== eg) begin fails++; $error("FAIL rr_ready: got %0h exp %0h", m_ready, eg); end
         m_wrq = ~eg;
         hbus_ready = 1'b0;
         tick();
         tests++; if (hbus_wrq !== 1'b0) begin fails++; $error("FAIL rr_drain_wrq: got %0h", hbus_wrq); end
         tick();
         tests++; if (m_gnt !== 2'b00) begin fails++; $error("FAIL rr_release: got %0h", m_gnt); end
      end
      m_wrq = '0;
      tick();

      m_rrq = 2'b01;
      #1;
      tests++; if (m_gnt !== 2'b00) begin fails++; $error("FAIL rd_pre_gnt: got %0h", m_gnt); end
      tests++; if (hbus_rrq !== 1'b0) begin fails++; $error("FAIL rd_pre_rrq: got %0h", hbus_rrq); end
      tick();
      tests++; if (m_gnt !== 2'b01) begin fails++; $error("FAIL rd_gnt: got %0h", m_gnt); end
      tests++; if (hbus_rrq !== 1'b1) begin fails++; $error("FAIL rd_rrq: got %0h", hbus_rrq); end
      tests++; if (hbus_adr_o !== 32'h100) begin fails++; $error("FAIL rd_adr: got %0h", hbus_adr_o); end
      hbus_busy  = 1'b1;
      hbus_valid = 1'b1;
      hbus_dat_i = 16'h1234;
      #1;
      tests++; if (m_valid !== 2'b01) begin fails++; $error("FAIL rd_valid1: got %0h", m_valid); end
      tests++; if (m_dat_o !== 16'h1234) begin fails++; $error("FAIL rd_dat: got %0h", m_dat_o); end
      tick();
      hbus_valid = 1'b0;
      #1;
      tests++; if (m_valid !== 2'b00) begin fails++; $error("FAIL rd_valid_gap: got %0h", m_valid); end
      tick();
      hbus_valid = 1'b1;
      #1;
      tests++; if (m_valid !== 2'b01) begin fails++; $error("FAIL rd_valid2: got %0h", m_valid); end
      tick();
      hbus_valid = 1'b0;
      m_rrq = 2'b00;
      tick();
      tests++; if (hbus_rrq !== 1'b0) begin fails++; $error("FAIL rd_drain_rrq: got %0h", hbus_rrq); end
      tests++; if (m_gnt !== 2'b01) begin fails++; $error("FAIL rd_drain_gnt: got %0h", m_gnt); end
      tick();
      tests++; if (m_gnt !== 2'b01) begin fails++; $error("FAIL rd_busy_hold: got %0h", m_gnt); end
      hbus_busy = 1'b0;
      tick();
      tests++; if (m_gnt !== 2'b00) begin fails++; $error("FAIL rd_release: got %0h", m_gnt); end
      tests++; if (hbus_adr_o !== 32'h0) begin fails++; $error("FAIL rd_adr_idle: got %0h", hbus_adr_o); end

      m_wrq = 2'b01;
      tick();
      tests++; if (m_gnt !== 2'b01) begin fails++; $error("FAIL nb_gnt0: got %0h", m_gnt); end
      hbus_busy  = 1'b1;
      hbus_ready = 1'b1;
      m_wrq = 2'b11;
      tick();
      tests++; if (m_ready !== 2'b01) begin fails++; $error("FAIL nb_ready: got %0h", m_ready); end
      tests++; if (hbus_wrq !== 1'b1) begin fails++; $error("FAIL nb_wrq: got %0h", hbus_wrq); end
      tick();
      tests++; if (m_gnt !== 2'b01) begin fails++; $error("FAIL nb_gnt_hold: got %0h", m_gnt); end
      m_wrq = 2'b10;
      hbus_busy  = 1'b0;
      hbus_ready = 1'b0;
      tick();
      tests++; if (hbus_wrq !== 1'b0) begin fails++; $error("FAIL nb_drain_wrq: got %0h", hbus_wrq); end
      tick();
      tests++; if (m_gnt !== 2'b00) begin fails++; $error("FAIL nb_idle_gnt: got %0h", m_gnt); end
      tick();
      tests++; if (m_gnt !== 2'b10) begin fails++; $error("FAIL nb_gnt1: got %0h", m_gnt); end
      tests++; if (hbus_wrq !== 1'b1) begin fails++; $error("FAIL nb_wrq1: got %0h", hbus_wrq); end
      m_wrq = 2'b00;
      tick(2);

      m_rrq = 2'b01;
      m_wrq = 2'b01;
      tick();
      tests++; if (m_gnt !== 2'b01) begin fails++; $error("FAIL rw_gnt: got %0h", m_gnt); end
      tests++; if (hbus_rrq !== 1'b1) begin fails++; $error("FAIL rw_rrq: got %0h", hbus_rrq); end
      tests++; if (hbus_wrq !== 1'b0) begin fails++; $error("FAIL rw_wrq: got %0h", hbus_wrq); end
      m_rrq = 2'b00;
      m_wrq = 2'b00;
      tick(2);

      hbus_busy = 1'b1;
      m_rrq = 2'b10;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++; if (m_gnt !== 2'b00) begin fails++; $error("FAIL busy_nogrant: got %0h", m_gnt); end
      end
      hbus_busy = 1'b0;
      tick();
      tests++; if (m_gnt !== 2'b10) begin fails++; $error("FAIL busy_gnt: got %0h", m_gnt); end
      tests++; if (hbus_adr_o !== 32'h200) begin fails++; $error("FAIL busy_adr: got %0h", hbus_adr_o); end
      m_rrq = 2'b00;
      tick(2);

      m_rrq = 2'b01;
      tick();
      tests++; if (m_gnt !== 2'b01) begin fails++; $error("FAIL ar_gnt: got %0h", m_gnt); end
      #2 hbus_rst = 1'b1;
      #1;
      tests++; if (m_gnt !== 2'b00) begin fails++; $error("FAIL ar_gnt_clr: got %0h", m_gnt); end
      tests++; if (hbus_rrq !== 1'b0) begin fails++; $error("FAIL ar_rrq_clr: got %0h", hbus_rrq); end
      m_rrq = 2'b11;
      @(negedge hbus_clk);
      hbus_rst = 1'b0;
      tick();
      tests++; if (m_gnt !== 2'b01) begin fails++; $error("FAIL ar_regrant: got %0h", m_gnt); end
      m_rrq = 2'b00;
      tick(2);

`ifdef HBUS_ARB_TIMEOUT_EN
      m_rrq = 2'b01;
      tick();
      tests++; if (m_gnt !== 2'b01) begin fails++; $error("FAIL to_gnt: got %0h", m_gnt); end
      tick(15);
      tests++; if (m_timeout !== 2'b00) begin fails++; $error("FAIL to_not_yet: got %0h", m_timeout); end
      tests++; if (hbus_rrq !== 1'b1) begin fails++; $error("FAIL to_rrq_on: got %0h", hbus_rrq); end
      m_rrq = 2'b11;
      tick();
      tests++; if (m_timeout !== 2'b01) begin fails++; $error("FAIL to_pulse: got %0h", m_timeout); end
      tests++; if (hbus_rrq !== 1'b0) begin fails++; $error("FAIL to_rrq_off: got %0h", hbus_rrq); end
      tick();
      tests++; if (m_timeout !== 2'b00) begin fails++; $error("FAIL to_pulse_end: got %0h", m_timeout); end
      tests++; if (m_gnt !== 2'b00) begin fails++; $error("FAIL to_release: got %0h", m_gnt); end
      tick();
      tests++; if (m_gnt !== 2'b10) begin fails++; $error("FAIL to_next: got %0h", m_gnt); end
      m_rrq = 2'b00;
      tick(2);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200000");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/hyperbus_arbiter.md
Name: hyperbus_arbiter

Overview:
Round-robin arbiter in the hbus_clk domain. It shares one Hyperbus native memory interface (the controller side) between NUM_PORTS requesters, such as several FIFO bridges or a DMA engine. A grant is held for the whole transaction and released only after the owner drops its request and the controller reports not busy. Control outputs are gated by the grant register; data, address and handshakes are muxed from the owner.

Parameters:
NUM_PORTS, 2, number of requesters; legal range 2..4
HBUS_ADDR_WIDTH, 32, address width
HBUS_DATA_WIDTH, 16, data beat width
TIMEOUT_CYCLES, 1024, watchdog limit (used only with HBUS_ARB_TIMEOUT_EN); must be >= 2

Ports:
hbus_clk  in  1  clock
hbus_rst  in  1  asynchronous, active-high reset
m_rrq  in  NUM_PORTS  per-port read request
m_wrq  in  NUM_PORTS  per-port write request
m_adr_i  in  NUM_PORTS*HBUS_ADDR_WIDTH  per-port address; port k at bits [k*AW +: AW]
m_dat_i  in  NUM_PORTS*HBUS_DATA_WIDTH  per-port write data
m_dat_o  out  HBUS_DATA_WIDTH  read data, broadcast to all ports
m_ready  out  NUM_PORTS  write-beat accept, routed to owner only
m_valid  out  NUM_PORTS  read-beat valid, routed to owner only
m_gnt  out  NUM_PORTS  one-hot grant, registered
m_timeout  out  NUM_PORTS  one-cycle watchdog abort pulse; constant 0 without the macro
hbus_adr_o  out  HBUS_ADDR_WIDTH  owner address
hbus_dat_o  out  HBUS_DATA_WIDTH  owner write data
hbus_dat_i  in  HBUS_DATA_WIDTH  controller read data
hbus_rrq  out  1  read request to controller
hbus_wrq  out  1  write request to controller
hbus_ready  in  1  controller write-beat accept
hbus_valid  in  1  controller read-beat valid
hbus_busy  in  1  controller transaction in progress

Behaviour:
- Reset: state=IDLE, m_gnt=0, last_port=NUM_PORTS-1, m_timeout=0, wd_cnt=0. Therefore hbus_rrq=0, hbus_wrq=0, m_ready=0 and m_valid=0.
- Port k requests when m_rrq[k] | m_wrq[k].
- States:
  - IDLE: if any port requests and hbus_busy=0, grant the first requesting port searching upward from last_port+1 (wrapping). Then m_gnt<=onehot(k), last_port<=k, state->OWN. If hbus_busy=1, no grant is issued.
  - OWN: hbus_rrq=m_rrq[own], hbus_wrq=m_wrq[own] (combinational through the grant). When the owner drops both requests, state->DRAIN.
  - DRAIN: hbus_rrq=hbus_wrq=0. When hbus_busy=0, m_gnt<=0 and state->IDLE.
- Latency: a request sampled in IDLE at cycle N is granted, and hbus_rrq/hbus_wrq rise, at cycle N+1. Release to the next grant takes at least 2 cycles (DRAIN, then IDLE).
- Muxing:
  - hbus_adr_o and hbus_dat_o come from the owner's slice. While no grant is held they are driven 0.
  - m_ready[k]=hbus_ready & m_gnt[k]; m_valid[k]=hbus_valid & m_gnt[k].
  - m_dat_o=hbus_dat_i, unconditionally.
- Simultaneous m_rrq and m_wrq on the owner: read wins. hbus_rrq=1, hbus_wrq=0.
- A non-owner asserting a request has no effect until the owner is released. Its requests stay pending; the arbiter does not capture them.
- Fairness: with all ports requesting continuously, grants rotate 0,1,...,N-1,0.
- Asynchronous reset mid-transaction: all outputs go to their reset values immediately. Masters must also be reset.

Optional Feature:
HBUS_ARB_TIMEOUT_EN:
- With the macro defined:
  - wd_cnt clears on every grant and increments each cycle in OWN or DRAIN.
  - When wd_cnt==TIMEOUT_CYCLES-1, the arbiter pulses m_timeout[own] for 1 cycle, forces state->DRAIN and gates hbus_rrq/hbus_wrq to 0.
  - The grant is then freed once hbus_busy=0. Before the aborted owner can be re-granted, it must drop its request for at least 1 cycle.
- Without the macro: no counter, m_timeout tied 0, and a grant is unbounded.

Decomposition:
- Package hyperbus_pkg holds:
  - the state encodings ARB_IDLE/ARB_OWN/ARB_DRAIN as one-hot localparams;
  - a function port_onehot(idx).
- Sub-module hyperbus_rr_pick: purely combinational round-robin picker, taking req[N] and last[log2 N] and returning gnt_onehot[N] and idx. It is reusable by other hbus arbiters.

Test Plan:
- Single port 0 read of 2 beats at adr 0x100: rrq rises at N+1 and hbus_adr_o=0x100. m_valid[0] pulses twice and m_valid[1] stays 0. m_gnt clears after busy falls.
- Ports 0 and 1 both assert wrq in the same cycle, repeated 4 times: grant order is 0,1,0,1. Each hbus_dat_o matches the owner (0xAAAA / 0x5555).
- Port 1 requests while port 0 owns: no m_ready[1] or glitch on hbus_wrq. Port 1 is granted 2 cycles after port 0 drops its request and busy=0.
- Owner asserts rrq and wrq together: hbus_rrq=1, hbus_wrq=0.
- hbus_busy held high in IDLE with a request pending: no grant. Grant follows busy falling by 1 cycle.
- With HBUS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, owner holds rrq forever: m_timeout[0] pulses at cycle 16 after the grant and hbus_rrq drops. Port 1 is granted after busy=0.
